// File: rtl/l1_mshr.sv
// Miss status holding register file between the L1 cache and the next level.
// Define MSHR_MERGE_EN to enable the line-address CAM that merges secondary misses.
module l1_mshr #(
    parameter int W        = 64,
    parameter int B        = 64,
    parameter int N        = 4,
    parameter int MAXMERGE = 4,
    localparam int CW      = $clog2(MAXMERGE + 1)
) (
    input  logic             clk_in,
    input  logic             rst_N_in,
    input  logic             miss_valid_in,
    input  logic [W-1:0]     miss_addr_in,
    output logic             miss_ready_out,
    output logic             mem_req_valid_out,
    output logic [W-1:0]     mem_req_addr_out,
    input  logic             mem_req_ready_in,
    input  logic             mem_resp_valid_in,
    input  logic [8*B-1:0]   mem_resp_data_in,
    output logic             fill_valid_out,
    output logic [W-1:0]     fill_addr_out,
    output logic [8*B-1:0]   fill_data_out,
    output logic [CW-1:0]    fill_count_out,
    input  logic             fill_ready_in,
    output logic             full_out,
    output logic             err_out
);
    localparam int LB = $clog2(B);
    localparam int LW = W - LB;
    localparam int PW = $clog2(N);
    localparam logic [PW:0] OCC_FULL = (PW + 1)'(N);

    typedef enum logic [1:0] {FREE, PENDING, ISSUED, FILLED} entryState_e;

    entryState_e      r_state [N];
    logic [LW-1:0]    r_line  [N];
    logic [CW-1:0]    r_count [N];
    logic [8*B-1:0]   r_data  [N];
    logic [PW-1:0]    r_allocPtr, r_issuePtr, r_respPtr, r_retirePtr;
    logic [PW:0]      r_occ;
    logic             r_err;

    logic [LW-1:0]    w_missLine;
    logic             w_full, w_alloc, w_issue, w_respOk, w_retire;
    logic             w_unused;

    assign w_missLine = miss_addr_in[W-1:LB];
    assign w_unused   = &{1'b0, miss_addr_in[LB-1:0]};
    assign w_full     = (r_occ == OCC_FULL);

`ifdef MSHR_MERGE_EN
    logic             w_match, w_canMerge, w_merge;
    logic [PW-1:0]    w_matchIdx;

    // At most one live entry per line exists, so the match is unique.
    always_comb begin
        w_match    = 1'b0;
        w_matchIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_state[i] != FREE && r_line[i] == w_missLine) begin
                w_match    = 1'b1;
                w_matchIdx = PW'(i);
            end
        end
    end

    assign w_canMerge     = w_match &&
                            (r_state[w_matchIdx] == PENDING || r_state[w_matchIdx] == ISSUED) &&
                            (r_count[w_matchIdx] < CW'(MAXMERGE));
    assign miss_ready_out = w_match ? w_canMerge : !w_full;
    assign w_merge        = miss_valid_in && w_canMerge;
    assign w_alloc        = miss_valid_in && !w_match && !w_full;
`else
    assign miss_ready_out = !w_full;
    assign w_alloc        = miss_valid_in && !w_full;
`endif

    assign w_issue  = mem_req_valid_out && mem_req_ready_in;
    assign w_respOk = mem_resp_valid_in && (r_state[r_respPtr] == ISSUED);
    assign w_retire = fill_valid_out && fill_ready_in;

    // Each event targets an entry in a distinct state, so writes never collide.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= FREE;
                r_line[i]  <= '0;
                r_count[i] <= '0;
                r_data[i]  <= '0;
            end
            r_allocPtr  <= '0;
            r_issuePtr  <= '0;
            r_respPtr   <= '0;
            r_retirePtr <= '0;
            r_occ       <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_state[r_allocPtr] <= PENDING;
                r_line[r_allocPtr]  <= w_missLine;
                r_count[r_allocPtr] <= CW'(1);
                r_allocPtr          <= r_allocPtr + 1'b1;
            end
`ifdef MSHR_MERGE_EN
            if (w_merge) begin
                r_count[w_matchIdx] <= r_count[w_matchIdx] + 1'b1;
            end
`endif
            if (w_issue) begin
                r_state[r_issuePtr] <= ISSUED;
                r_issuePtr          <= r_issuePtr + 1'b1;
            end
            if (w_respOk) begin
                r_state[r_respPtr] <= FILLED;
                r_data[r_respPtr]  <= mem_resp_data_in;
                r_respPtr          <= r_respPtr + 1'b1;
            end else if (mem_resp_valid_in) begin
                r_err <= 1'b1;
            end
            if (w_retire) begin
                r_state[r_retirePtr] <= FREE;
                r_retirePtr          <= r_retirePtr + 1'b1;
            end
            if (w_alloc && !w_retire) begin
                r_occ <= r_occ + 1'b1;
            end else if (!w_alloc && w_retire) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    assign mem_req_valid_out = (r_state[r_issuePtr] == PENDING);
    assign mem_req_addr_out  = {r_line[r_issuePtr], {LB{1'b0}}};
    assign fill_valid_out    = (r_state[r_retirePtr] == FILLED);
    assign fill_addr_out     = {r_line[r_retirePtr], {LB{1'b0}}};
    assign fill_data_out     = r_data[r_retirePtr];
    assign fill_count_out    = r_count[r_retirePtr];
    assign full_out          = w_full;
    assign err_out           = r_err;
endmodule
